orbtrace_housekeeping: RTL
==========================

Name: orbtrace_housekeeping

Overview:
Parametrised housekeeping and indicator block for the orbtrace FPGA top level. It sequences the system reset from PLL lock with lock filtering and a hold-off. It drives a heartbeat LED whose blink rate encodes trace sync state. It drives NUM_IND activity/status LEDs from asynchronous event inputs, each with a per-channel mode: pulse stretch, level follow, or sticky.

Parameters:
HB_BITS, 26, heartbeat counter width; slow blink = bit HB_BITS-1, fast blink = bit HB_BITS-3 (HB_BITS >= 4)
NUM_IND, 4, number of indicator channels (1..16)
IND_MODE, {NUM_IND{2'b00}}, 2 bits per channel, ch i = IND_MODE[2i+1:2i]; 00 stretch, 01 level, 10 sticky, 11 reserved (treated as stretch)
STRETCH_CYCLES, 2_400_000, LED on-time in clkOut cycles for stretch mode (>= 1)
LOCK_FILTER, 1024, consecutive synchronised lock-high cycles required (>= 1)
RST_HOLD_CYCLES, 4096, extra cycles sysRst stays high after filter passes (>= 1)

Ports:
clkOut  input  1  system clock (PLL output)
rst  input  1  synchronous, active-high reset
lockIn  input  1  PLL lock, asynchronous
syncIn  input  1  trace sync flag, clkOut domain
indEvt  input  NUM_IND  event/level inputs, asynchronous
indClr  input  NUM_IND  clears sticky channels, clkOut domain, level
sysRst  output  1  registered system reset, active-high
hbLed  output  1  registered heartbeat LED
indLed  output  NUM_IND  registered indicator LEDs

Behaviour:
- Reset (rst=1 at a clkOut edge): sysRst=1, hbLed=0, indLed=0, all counters=0, synchronisers=0, FSM=WAIT_LOCK. Reset is only synchronous; rst mid-operation aborts any stretch, sticky or hold in progress.
- lockIn and each indEvt bit pass through 2-FF synchronisers (lock_s, evt_s).
- Reset FSM:
  - WAIT_LOCK: filter counter increments on each edge with lock_s=1 and clears on lock_s=0. Reaching LOCK_FILTER -> HOLD, hold counter=0.
  - HOLD: hold counter increments each edge. Reaching RST_HOLD_CYCLES -> RUN. lock_s=0 -> WAIT_LOCK, counters cleared.
  - RUN: lock_s=0 -> WAIT_LOCK.
  - sysRst is registered = (next state != RUN).
- sysRst timing: with n0 = first edge sampling lockIn=1 (lock held stable), sysRst goes low after edge n0+1+LOCK_FILTER+RST_HOLD_CYCLES.
- Lock loss in RUN: the first edge seeing lock_s=0 sets sysRst=1, i.e. 3 edges after lockIn is first sampled low.
- Heartbeat:
  - Counter is free-running while sysRst=0 and held at 0 while sysRst=1; it wraps modulo 2^HB_BITS.
  - hbLed = 0 when sysRst=1; cnt[HB_BITS-1] when syncIn=1; cnt[HB_BITS-3] when syncIn=0. Registered, 1-cycle latency.
- Indicators: per channel, an edge detector produces rise = evt_s & ~evt_s_d.
  - Stretch: rise loads the down-counter with STRETCH_CYCLES. indLed=1 while counter != 0, and the counter decrements each edge. A rise while active reloads the counter (retrigger extends, no gap). indLed asserts after the edge at which rise is seen, i.e. edge n+3 relative to the first edge sampling indEvt=1. It stays high for exactly STRETCH_CYCLES cycles after the last rise.
  - Level: indLed = evt_s_d, giving 3-edge latency, same as stretch.
  - Sticky: rise sets indLed. indClr[i]=1 clears it. Simultaneous rise and indClr: set wins.
  - indClr is ignored in stretch and level modes.
- Indicator channels operate independently of sysRst; only rst clears them.
- Counters are sized $clog2(param+1); no arithmetic overflow is possible.

Test Plan:
(Bench parameters: HB_BITS=6, NUM_IND=3, IND_MODE=6'b10_01_00, STRETCH_CYCLES=8, LOCK_FILTER=4, RST_HOLD_CYCLES=6.)
1. rst 2 cycles, then lockIn=1 from edge n0 -> sysRst=1 through edge n0+10, 0 after edge n0+11; hbLed=0 before that.
2. lockIn glitch low for 1 cycle during HOLD -> FSM returns to WAIT_LOCK, full 4+6 sequence restarts, sysRst never deasserts early; in RUN lockIn=0 at edge m -> sysRst=1 after edge m+2.
3. RUN, syncIn=1 -> hbLed period 64 cycles (32 high/32 low); syncIn=0 -> period 16 cycles.
4. Channel 0 (stretch): 1-cycle pulse on indEvt[0] -> indLed[0] high after edge n+3 for exactly 8 cycles. Second pulse 5 cycles after the first -> continuous high, ending 8 cycles after the second rise.
5. Channel 1 (level): indEvt[1] high for 20 cycles -> indLed[1] high for 20 cycles, delayed 3 edges.
6. Channel 2 (sticky): pulse -> indLed[2] stays 1; indClr[2]=1 with no rise -> 0 next edge; rise coincident with indClr -> stays 1; rst asserted mid-stretch on ch0 -> all indLed=0 next edge.

Source files
------------

// File: rtl/orbtrace_housekeeping.sv
// rtl/orbtrace_housekeeping.sv - reset sequencing, heartbeat and indicator LEDs
//
// Purpose:
//   Sequences the system reset from PLL lock (lock filter + hold-off), drives a
//   heartbeat LED whose blink rate encodes trace sync state, and drives NUM_IND
//   indicator LEDs from asynchronous events in stretch, level or sticky mode.
//
// Ports:
//   clkOut  in   system clock (PLL output)
//   rst     in   synchronous, active-high reset
//   lockIn  in   PLL lock, asynchronous
//   syncIn  in   trace sync flag, clkOut domain
//   indEvt  in   [NUM_IND] event/level inputs, asynchronous
//   indClr  in   [NUM_IND] sticky-channel clear, clkOut domain, level
//   sysRst  out  registered system reset, active-high
//   hbLed   out  registered heartbeat LED
//   indLed  out  [NUM_IND] registered indicator LEDs
module orbtrace_housekeeping #(
  parameter int                     HB_BITS         = 26,
  parameter int                     NUM_IND         = 4,
  parameter logic [2*NUM_IND-1:0]   IND_MODE        = {NUM_IND{2'b00}},
  parameter int                     STRETCH_CYCLES  = 2_400_000,
  parameter int                     LOCK_FILTER     = 1024,
  parameter int                     RST_HOLD_CYCLES = 4096
) (
  input  logic               clkOut,
  input  logic               rst,
  input  logic               lockIn,
  input  logic               syncIn,
  input  logic [NUM_IND-1:0] indEvt,
  input  logic [NUM_IND-1:0] indClr,
  output logic               sysRst,
  output logic               hbLed,
  output logic [NUM_IND-1:0] indLed
);

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  localparam logic [FW-1:0] FILTER_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH_VAL = SW'(STRETCH_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } rstState_t;

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic               lockMeta;
  logic               lockS;
  logic [NUM_IND-1:0] evtMeta;
  logic [NUM_IND-1:0] evtS;
  logic [NUM_IND-1:0] evtSd;

  always_ff @(posedge clkOut) begin
    if (rst) begin
      lockMeta <= 1'b0;
      lockS    <= 1'b0;
      evtMeta  <= '0;
      evtS     <= '0;
      evtSd    <= '0;
    end else begin
      lockMeta <= lockIn;
      lockS    <= lockMeta;
      evtMeta  <= indEvt;
      evtS     <= evtMeta;
      evtSd    <= evtS;
    end
  end

  // ---------------------------------------------------------------------------
  // Reset sequencing FSM
  // ---------------------------------------------------------------------------
  rstState_t         state;
  rstState_t         nextState;
  logic [FW-1:0]     filterCnt;
  logic [HW-1:0]     holdCnt;
  logic              sysRstNext;

  always_ff @(posedge clkOut) begin
    if (rst) begin
      state <= ST_WAIT_LOCK;
    end else begin
      state <= nextState;
    end
  end

  // A transition fires on the edge where the counter would reach its target,
  // so the counter value itself never has to be compared against the limit.
  always_comb begin
    nextState = state;
    case (state)
      ST_WAIT_LOCK: begin
        if (lockS && (filterCnt == FILTER_LAST)) begin
          nextState = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!lockS) begin
          nextState = ST_WAIT_LOCK;
        end else if (holdCnt == HOLD_LAST) begin
          nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lockS) begin
          nextState = ST_WAIT_LOCK;
        end
      end
      default: nextState = ST_WAIT_LOCK;
    endcase
  end

  // sysRst is registered from the next state so it drops on the same edge the
  // FSM enters RUN and rises on the first edge that sees lock lost.
  always_comb begin
    sysRstNext = (nextState != ST_RUN);
  end

  always_ff @(posedge clkOut) begin
    if (rst) begin
      filterCnt <= '0;
      holdCnt   <= '0;
      sysRst    <= 1'b1;
    end else begin
      sysRst <= sysRstNext;
      case (state)
        ST_WAIT_LOCK: begin
          filterCnt <= lockS ? filterCnt + 1'b1 : '0;
          holdCnt   <= '0;
        end
        ST_HOLD: begin
          if (!lockS) begin
            filterCnt <= '0;
            holdCnt   <= '0;
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        default: begin
          filterCnt <= '0;
          holdCnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Heartbeat
  // ---------------------------------------------------------------------------
  logic [HB_BITS-1:0] hbCnt;

  always_ff @(posedge clkOut) begin
    if (rst) begin
      hbCnt <= '0;
      hbLed <= 1'b0;
    end else begin
      hbCnt <= sysRst ? '0 : hbCnt + 1'b1;
      if (sysRst) begin
        hbLed <= 1'b0;
      end else if (syncIn) begin
        hbLed <= hbCnt[HB_BITS-1];
      end else begin
        hbLed <= hbCnt[HB_BITS-3];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Indicator channels (independent of sysRst)
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_IND; i++) begin : gInd
    localparam logic [1:0] MODE     = IND_MODE[2*i+1:2*i];
    localparam bit         IS_LEVEL  = (MODE == 2'b01);
    localparam bit         IS_STICKY = (MODE == 2'b10);
    // Reserved encoding 11 falls back to stretch.
    localparam bit         IS_STRETCH = !IS_LEVEL && !IS_STICKY;

    logic          rise;
    logic [SW-1:0] stretchCnt;
    logic          ledQ;

    assign rise      = evtS[i] & ~evtSd[i];
    assign indLed[i] = ledQ;

    always_ff @(posedge clkOut) begin
      if (rst) begin
        stretchCnt <= '0;
        ledQ       <= 1'b0;
      end else begin
        // A rise while already counting reloads, so retriggers extend with no gap.
        if (IS_STRETCH && rise) begin
          stretchCnt <= STRETCH_VAL;
        end else if (stretchCnt != '0) begin
          stretchCnt <= stretchCnt - 1'b1;
        end

        if (IS_LEVEL) begin
          ledQ <= evtSd[i];
        end else if (IS_STICKY) begin
          // Set has priority over a coincident clear.
          if (rise) begin
            ledQ <= 1'b1;
          end else if (indClr[i]) begin
            ledQ <= 1'b0;
          end
        end else begin
          ledQ <= (stretchCnt != '0);
        end
      end
    end
  end

endmodule
